regbank_sb: RTL

REGBANK_SB -- requirements
Module: regbank_sb

---
 rtl/regbank_pkg.sv | 28 ++
 rtl/regbank_scoreboard.sv | 78 +++++++
 rtl/regbank_sb.sv | 109 ++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: default sizing and busy/error encodings
// shared by the register bank and its scoreboard.
package regbank_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 14;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_N_RD     = 2;
  localparam bit DEF_ZERO_REG = 1'b0;

  typedef enum logic {
    BUSY_FREE = 1'b0,
    BUSY_PEND = 1'b1
  } busy_e;

  typedef enum logic {
    ERR_NONE = 1'b0,
    ERR_ADDR = 1'b1
  } err_e;

  function automatic logic in_range(
    input logic [31:0] a,
    input logic [31:0] depth
  );
    return a < depth;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: per-register pending-result bits
// with claim/clear update and per-read-port busy lookup.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter bit ZERO_REG = DEF_ZERO_REG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_busy,
  output logic [DEPTH-1:0]       busy_vec
);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  claim_hit;
  logic [DEPTH-1:0]  clr_hit;
  logic              claim_ok;
  logic [ADDR_W-1:0] ra [N_RD];

  for (genvar k = 0; k < N_RD; k++) begin : g_ra
    assign ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  // register 0 never goes busy when it is hardwired
  assign claim_ok = claim_en
                 && in_range(32'(claim_addr), 32'(DEPTH))
                 && !(ZERO_REG && claim_addr == '0);

  always_comb begin
    claim_hit = '0;
    clr_hit   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      claim_hit[i] = claim_ok && claim_addr == ADDR_W'(i);
      clr_hit[i]   = clr_en && clr_addr == ADDR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (claim_hit[i]) begin
          busy_q[i] <= BUSY_PEND;
        end else if (clr_hit[i]) begin
          busy_q[i] <= BUSY_FREE;
        end
      end
    end
  end

  // a bypassed write hides the pending bit unless re-claimed
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < N_RD; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ra[k] == ADDR_W'(i)) begin
          rd_busy[k] = busy_q[i]
                    && !(clr_hit[i] && !claim_hit[i]);
        end
      end
      if (ZERO_REG && ra[k] == '0) begin
        rd_busy[k] = 1'b0;
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regbank_sb.sv
// regbank_sb: multi-port register bank with write bypass,
// illegal-address error pulse and a result scoreboard.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter bit ZERO_REG = DEF_ZERO_REG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr_wr,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  output logic                   wr_err,
  output logic [DEPTH-1:0]       busy_vec
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra [N_RD];
  logic              wr_legal;
  logic              wr_store;
  logic [DEPTH-1:0]  wr_hit;

  for (genvar k = 0; k < N_RD; k++) begin : g_ra
    assign ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  assign wr_legal = we
                 && in_range(32'(addr_wr), 32'(DEPTH));

  // writes to a hardwired register 0 are dropped silently
  assign wr_store = wr_legal
                 && !(ZERO_REG && addr_wr == '0);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_hit[i] = wr_store && addr_wr == ADDR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem[i] <= data_in;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= ERR_NONE;
    end else if (we && !wr_legal) begin
      wr_err <= ERR_ADDR;
    end else begin
      wr_err <= ERR_NONE;
    end
  end

  // out-of-range addresses match no register and read zero
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_RD; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ra[k] == ADDR_W'(i)) begin
          rd_data[k*DATA_W +: DATA_W] = mem[i];
        end
      end
      if (wr_legal && addr_wr == ra[k]) begin
        rd_data[k*DATA_W +: DATA_W] = data_in;
      end
      if (ZERO_REG && ra[k] == '0) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  regbank_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .clr_en     (wr_legal),
    .clr_addr   (addr_wr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .busy_vec   (busy_vec)
  );

endmodule
